// File: rtl/glitch_pulse_gen.sv
// Programmable glitch pulse generator: armed by command, waits for a trigger,
// then emits a delay/width/gap pulse train with a repeat count and abort.
module glitch_pulse_gen #(
   parameter int CNT_W = 16,
   parameter int REP_W = 8
) (
   input  logic             clk_in1,
   input  logic             rst,
   input  logic [CNT_W-1:0] cfg_delay,
   input  logic [CNT_W-1:0] cfg_width,
   input  logic [CNT_W-1:0] cfg_gap,
   input  logic [REP_W-1:0] cfg_repeat,
   input  logic             cfg_auto,
   input  logic             arm,
   input  logic             trigger,
   input  logic             abort,
   output logic             glitch_out,
   output logic             armed,
   output logic             busy,
   output logic             done,
   output logic [REP_W-1:0] pulse_cnt
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ARMED = 3'd1;
   localparam logic [2:0] S_DELAY = 3'd2;
   localparam logic [2:0] S_HIGH  = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;

   logic [2:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_delay;
   logic [CNT_W-1:0] r_width;
   logic [CNT_W-1:0] r_gap;
   logic [REP_W-1:0] r_repeat;
   logic [REP_W-1:0] r_pulse_cnt;
   logic             r_glitch;
   logic             r_done;

   logic             w_cnt_zero;
   logic [CNT_W-1:0] w_cnt_dec;
   logic [CNT_W-1:0] w_width_m1;
   logic [CNT_W-1:0] w_gap_m1;
   logic [REP_W-1:0] w_pc_next;
   logic             w_last;

   // Zero width/gap behave as one cycle, so the reload value saturates at zero.
   assign w_width_m1 = (r_width == '0) ? '0 : r_width - 1'b1;
   assign w_gap_m1   = (r_gap == '0) ? '0 : r_gap - 1'b1;
   assign w_cnt_zero = (r_cnt == '0);
   assign w_cnt_dec  = w_cnt_zero ? '0 : r_cnt - 1'b1;
   assign w_pc_next  = r_pulse_cnt + 1'b1;
   assign w_last     = (r_repeat != '0) && (w_pc_next == r_repeat);

   always_ff @(posedge clk_in1) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_delay     <= '0;
         r_width     <= '0;
         r_gap       <= '0;
         r_repeat    <= '0;
         r_pulse_cnt <= '0;
         r_glitch    <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (abort) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_glitch <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (arm) begin
                     r_delay     <= cfg_delay;
                     r_width     <= cfg_width;
                     r_gap       <= cfg_gap;
                     r_repeat    <= cfg_repeat;
                     r_pulse_cnt <= '0;
                     if (cfg_auto) begin
                        r_state <= S_DELAY;
                        r_cnt   <= cfg_delay;
                     end else begin
                        r_state <= S_ARMED;
                     end
                  end
               end
               S_ARMED: begin
                  if (trigger) begin
                     r_state <= S_DELAY;
                     r_cnt   <= r_delay;
                  end
               end
               S_DELAY: begin
                  if (w_cnt_zero) begin
                     r_state  <= S_HIGH;
                     r_glitch <= 1'b1;
                     r_cnt    <= w_width_m1;
                  end else begin
                     r_cnt <= w_cnt_dec;
                  end
               end
               S_HIGH: begin
                  if (w_cnt_zero) begin
                     r_glitch    <= 1'b0;
                     r_pulse_cnt <= w_pc_next;
                     if (w_last) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                     end else begin
                        r_state <= S_GAP;
                        r_cnt   <= w_gap_m1;
                     end
                  end else begin
                     r_cnt <= w_cnt_dec;
                  end
               end
               S_GAP: begin
                  if (w_cnt_zero) begin
                     r_state  <= S_HIGH;
                     r_glitch <= 1'b1;
                     r_cnt    <= w_width_m1;
                  end else begin
                     r_cnt <= w_cnt_dec;
                  end
               end
               default: begin
                  r_state  <= S_IDLE;
                  r_glitch <= 1'b0;
               end
            endcase
         end
      end
   end

   assign glitch_out = r_glitch;
   assign done       = r_done;
   assign pulse_cnt  = r_pulse_cnt;
   assign armed      = (r_state == S_ARMED);
   assign busy       = (r_state == S_DELAY) || (r_state == S_HIGH) || (r_state == S_GAP);

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Directed bench for glitch_pulse_gen: pulse trains, auto mode, abort and reset.
module tb_glitch_pulse_gen;

   logic        clk_in1 = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cfg_delay = '0;
   logic [15:0] cfg_width = '0;
   logic [15:0] cfg_gap = '0;
   logic [7:0]  cfg_repeat = '0;
   logic        cfg_auto = 1'b0;
   logic        arm = 1'b0;
   logic        trigger = 1'b0;
   logic        abort = 1'b0;
   logic        glitch_out;
   logic        armed;
   logic        busy;
   logic        done;
   logic [7:0]  pulse_cnt;

   int n_checks = 0;
   int n_fail = 0;

   glitch_pulse_gen #(.CNT_W(16), .REP_W(8)) dut (
      .clk_in1   (clk_in1),
      .rst       (rst),
      .cfg_delay (cfg_delay),
      .cfg_width (cfg_width),
      .cfg_gap   (cfg_gap),
      .cfg_repeat(cfg_repeat),
      .cfg_auto  (cfg_auto),
      .arm       (arm),
      .trigger   (trigger),
      .abort     (abort),
      .glitch_out(glitch_out),
      .armed     (armed),
      .busy      (busy),
      .done      (done),
      .pulse_cnt (pulse_cnt)
   );

   always #5 clk_in1 = ~clk_in1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs set before a step are sampled at that step's edge; outputs read 1 time unit later.
   task automatic step();
      @(posedge clk_in1);
      #1;
   endtask

   task automatic set_cfg(input int d, input int w, input int g, input int r, input logic au);
      cfg_delay  = 16'(d);
      cfg_width  = 16'(w);
      cfg_gap    = 16'(g);
      cfg_repeat = 8'(r);
      cfg_auto   = au;
   endtask

   // Steps n edges after the start edge (t=1..n) and checks glitch_out/done against
   // the timing contract: pulse i high for t in [1+D+i*P, D+W'+i*P], P=W'+G'.
   task automatic check_train(input int d, input int w, input int g, input int r, input int n);
      int wp, gp, p, m;
      logic exp_g, exp_d;
      wp = (w == 0) ? 1 : w;
      gp = (g == 0) ? 1 : g;
      p  = wp + gp;
      for (int t = 1; t <= n; t++) begin
         step();
         arm = 1'b0;
         exp_g = 1'b0;
         if (t >= 1 + d) begin
            m = t - 1 - d;
            if ((m % p) < wp && (r == 0 || (m / p) < r)) exp_g = 1'b1;
         end
         exp_d = (r != 0) && (t == d + wp + (r - 1) * p + 1);
         check($sformatf("glitch t=%0d", t), 32'(glitch_out), 32'(exp_g));
         check($sformatf("done t=%0d", t), 32'(done), 32'(exp_d));
      end
   endtask

   initial begin
      // Reset state
      step();
      step();
      check("rst glitch", 32'(glitch_out), 0);
      check("rst armed", 32'(armed), 0);
      check("rst busy", 32'(busy), 0);
      check("rst done", 32'(done), 0);
      check("rst pcnt", 32'(pulse_cnt), 0);
      rst = 1'b0;

      // Trigger in IDLE is ignored
      trigger = 1'b1;
      step();
      step();
      check("idle trig armed", 32'(armed), 0);
      check("idle trig busy", 32'(busy), 0);
      check("idle trig glitch", 32'(glitch_out), 0);

      // Test 1: D=3 W=2 G=1 R=1, trigger together with arm must not start the run
      set_cfg(3, 2, 1, 1, 1'b0);
      arm = 1'b1;
      step();
      arm = 1'b0;
      trigger = 1'b0;
      check("t1 armed", 32'(armed), 1);
      check("t1 not busy", 32'(busy), 0);
      for (int i = 0; i < 7; i++) step();
      check("t1 still armed", 32'(armed), 1);
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      check("t1 busy", 32'(busy), 1);
      check("t1 armed off", 32'(armed), 0);
      check_train(3, 2, 1, 1, 8);
      check("t1 pcnt", 32'(pulse_cnt), 1);
      check("t1 idle busy", 32'(busy), 0);
      check("t1 idle armed", 32'(armed), 0);

      // Test 2: D=0 W=1 G=2 R=3 -> pulses at t=1,4,7, done at t=8
      set_cfg(0, 1, 2, 3, 1'b0);
      arm = 1'b1;
      step();
      arm = 1'b0;
      check("t2 pcnt cleared", 32'(pulse_cnt), 0);
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      check_train(0, 1, 2, 3, 10);
      check("t2 pcnt", 32'(pulse_cnt), 3);

      // Test 3: W=0 G=0 R=2 D=2; re-arm and cfg change mid-run have no effect
      set_cfg(2, 0, 0, 2, 1'b0);
      arm = 1'b1;
      step();
      arm = 1'b0;
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      set_cfg(9, 5, 7, 0, 1'b1);
      arm = 1'b1;
      check_train(2, 0, 0, 2, 8);
      check("t3 pcnt", 32'(pulse_cnt), 2);
      check("t3 idle armed", 32'(armed), 0);
      check("t3 idle busy", 32'(busy), 0);

      // Test 4: auto mode, R=0, D=1 W=1 G=1 -> pulses at t=2,4,6...; abort at t=15
      set_cfg(1, 1, 1, 0, 1'b1);
      arm = 1'b1;
      step();
      arm = 1'b0;
      check("t4 busy", 32'(busy), 1);
      check_train(1, 1, 1, 0, 14);
      check("t4 pcnt pre-abort", 32'(pulse_cnt), 6);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("t4 abort glitch", 32'(glitch_out), 0);
      check("t4 abort busy", 32'(busy), 0);
      check("t4 abort armed", 32'(armed), 0);
      check("t4 abort done", 32'(done), 0);
      check("t4 abort pcnt", 32'(pulse_cnt), 6);
      step();
      check("t4 abort no done", 32'(done), 0);
      check("t4 stays idle", 32'(glitch_out), 0);

      // Test 5: rst during HIGH together with abort and arm
      set_cfg(0, 4, 1, 1, 1'b0);
      arm = 1'b1;
      step();
      arm = 1'b0;
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      step();
      check("t5 high", 32'(glitch_out), 1);
      rst = 1'b1;
      abort = 1'b1;
      arm = 1'b1;
      step();
      check("t5 rst glitch", 32'(glitch_out), 0);
      check("t5 rst busy", 32'(busy), 0);
      check("t5 rst armed", 32'(armed), 0);
      check("t5 rst done", 32'(done), 0);
      check("t5 rst pcnt", 32'(pulse_cnt), 0);
      rst = 1'b0;
      abort = 1'b0;
      arm = 1'b0;
      step();
      check("t5 idle armed", 32'(armed), 0);
      check("t5 idle busy", 32'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
